// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the register file (8 general registers plus SP/IH/T).
// Writeback has fixed priority. Loader/debug writes queue in a 2-entry FIFO.
// A starvation counter raises stall_req so that a queued loader entry always
// drains even under a continuous writeback stream. All rf_* outputs come
// straight from flops.
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 16
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              freeze,
    input  logic              wb_valid,
    input  logic [1:0]        wb_spec,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [1:0]        ld_spec,
    input  logic [2:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              rf_regWrite,
    output logic [1:0]        rf_writeSpecReg,
    output logic [2:0]        rf_R3,
    output logic [DATA_W-1:0] rf_inData3,
    output logic              stall_req,
    output logic [1:0]        ld_count
);

    localparam int ENTRY_W = 2 + 3 + DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } arbState_t;

    arbState_t state, stateNext;

    logic [ENTRY_W-1:0] fifoMem [2];
    logic               rdPtr;
    logic               wrPtr;
    logic [1:0]         count;
    logic [1:0]         countNext;
    logic [ENTRY_W-1:0] headEntry;

    logic [3:0]         starveCnt;
    logic [3:0]         starveCntNext;
    logic               stallReq;

    logic               push;
    logic               pop;
    logic               fifoNotEmpty;
    logic               wbGrant;
    logic               ldGrant;

    logic               wrVld_p1;
    logic [1:0]         wrSpec_p1;
    logic [2:0]         wrAddr_p1;
    logic [DATA_W-1:0]  wrData_p1;

    // Handshake and grant decode; ready looks only at the registered count,
    // so a same-cycle pop never lets a full FIFO take a new entry.
    assign ld_ready     = (count != 2'd2);
    assign push         = ld_valid & ld_ready;
    assign fifoNotEmpty = (count != 2'd0);
    assign wbGrant      = ~freeze & wb_valid;
    assign ldGrant      = ~freeze & ~wb_valid & fifoNotEmpty;
    assign pop          = ldGrant;
    assign countNext    = count + {1'b0, push} - {1'b0, pop};
    assign headEntry    = fifoMem[rdPtr];

    // Next-state and starvation-counter logic
    always_comb begin
        stateNext     = state;
        starveCntNext = starveCnt;
        case (state)
            IDLE: begin
                // IDLE means "FIFO empty": leave it on any push, even during
                // freeze, so the starvation counter can run once freeze lifts.
                starveCntNext = 4'd0;
                if (push) begin
                    stateNext = PEND;
                end
            end
            PEND: begin
                if (ldGrant) begin
                    starveCntNext = 4'd0;
                    stateNext     = (countNext == 2'd0) ? IDLE : PEND;
                end else if (!freeze && starveCnt == 4'(STARVE_LIMIT)) begin
                    stateNext = FORCE;
                end else if (wbGrant && fifoNotEmpty) begin
                    starveCntNext = starveCnt + 4'd1;
                end
            end
            FORCE: begin
                // Writeback may still win here to absorb in-flight work;
                // the first loader grant releases the stall.
                if (ldGrant) begin
                    starveCntNext = 4'd0;
                    stateNext     = (countNext == 2'd0) ? IDLE : PEND;
                end
            end
            default: begin
                stateNext     = IDLE;
                starveCntNext = 4'd0;
            end
        endcase
    end

    // Control state: FSM, counter, stall request and FIFO bookkeeping
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= IDLE;
            starveCnt <= 4'd0;
            stallReq  <= 1'b0;
            count     <= 2'd0;
            rdPtr     <= 1'b0;
            wrPtr     <= 1'b0;
        end else begin
            state     <= stateNext;
            starveCnt <= starveCntNext;
            stallReq  <= (stateNext == FORCE);
            count     <= countNext;
            if (push) begin
                wrPtr <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
        end
    end

    // FIFO storage; reset flushes it through the pointers and count
    always_ff @(posedge CLK) begin
        if (push) begin
            fifoMem[wrPtr] <= {ld_spec, ld_addr, ld_data};
        end
    end

    // Write-port register stage: load the winner, hold fields when idle
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wrVld_p1  <= 1'b0;
            wrSpec_p1 <= 2'd0;
            wrAddr_p1 <= 3'd0;
            wrData_p1 <= '0;
        end else begin
            wrVld_p1 <= wbGrant | ldGrant;
            if (wbGrant) begin
                wrSpec_p1 <= wb_spec;
                wrAddr_p1 <= wb_addr;
                wrData_p1 <= wb_data;
            end else if (ldGrant) begin
                {wrSpec_p1, wrAddr_p1, wrData_p1} <= headEntry;
            end
        end
    end

    assign rf_regWrite     = wrVld_p1;
    assign rf_writeSpecReg = wrSpec_p1;
    assign rf_R3           = wrAddr_p1;
    assign rf_inData3      = wrData_p1;
    assign stall_req       = stallReq;
    assign ld_count        = count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a write-order scoreboard.
module tb_regfile_write_arbiter;

    logic        CLK;
    logic        RST_n;
    logic        freeze;
    logic        wb_valid;
    logic [1:0]  wb_spec;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [1:0]  ld_spec;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic        rf_regWrite;
    logic [1:0]  rf_writeSpecReg;
    logic [2:0]  rf_R3;
    logic [15:0] rf_inData3;
    logic        stall_req;
    logic [1:0]  ld_count;

    int checks = 0;
    int errors = 0;
    logic [20:0] expQ[$];
    logic [20:0] sbExp;

    regfile_write_arbiter #(.STARVE_LIMIT(4), .DATA_W(16)) dut (
        .CLK(CLK), .RST_n(RST_n), .freeze(freeze),
        .wb_valid(wb_valid), .wb_spec(wb_spec), .wb_addr(wb_addr), .wb_data(wb_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_spec(ld_spec), .ld_addr(ld_addr), .ld_data(ld_data),
        .rf_regWrite(rf_regWrite), .rf_writeSpecReg(rf_writeSpecReg),
        .rf_R3(rf_R3), .rf_inData3(rf_inData3),
        .stall_req(stall_req), .ld_count(ld_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic setWb(input logic v, input logic [1:0] s, input logic [2:0] a, input logic [15:0] d);
        wb_valid = v; wb_spec = s; wb_addr = a; wb_data = d;
    endtask

    task automatic setLd(input logic v, input logic [1:0] s, input logic [2:0] a, input logic [15:0] d);
        ld_valid = v; ld_spec = s; ld_addr = a; ld_data = d;
    endtask

    // Scoreboard: every write seen on the port must match the next expected one
    always @(negedge CLK) begin
        if (RST_n === 1'b1 && rf_regWrite === 1'b1) begin
            check("sbHasEntry", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                sbExp = expQ.pop_front();
                check("sbWrite", {11'd0, rf_writeSpecReg, rf_R3, rf_inData3}, {11'd0, sbExp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_n  = 1'b0;
        freeze = 1'b0;
        setWb(1'b0, 2'd0, 3'd0, 16'h0);
        setLd(1'b0, 2'd0, 3'd0, 16'h0);

        // Reset values before any clock edge
        #2;
        check("rstRegWrite", 32'(rf_regWrite), 32'd0);
        check("rstSpec", 32'(rf_writeSpecReg), 32'd0);
        check("rstR3", 32'(rf_R3), 32'd0);
        check("rstData", 32'(rf_inData3), 32'd0);
        check("rstStall", 32'(stall_req), 32'd0);
        check("rstCount", 32'(ld_count), 32'd0);
        check("rstReady", 32'(ld_ready), 32'd1);
        tick(); tick();
        RST_n = 1'b1;

        // Fill the FIFO under freeze, issue one writeback, then reset mid-operation
        freeze = 1'b1;
        setLd(1'b1, 2'b00, 3'd1, 16'h1111);
        tick();
        setLd(1'b1, 2'b00, 3'd2, 16'h2222);
        tick();
        check("fillCount", 32'(ld_count), 32'd2);
        check("fillReady", 32'(ld_ready), 32'd0);
        freeze = 1'b0;
        setLd(1'b0, 2'b00, 3'd0, 16'h0);
        setWb(1'b1, 2'b00, 3'd2, 16'h7777);
        tick();
        check("preRstWrite", 32'(rf_regWrite), 32'd1);
        check("preRstData", 32'(rf_inData3), 32'h7777);
        setWb(1'b0, 2'b00, 3'd0, 16'h0);
        #1 RST_n = 1'b0;
        #1;
        check("midRstRegWrite", 32'(rf_regWrite), 32'd0);
        check("midRstData", 32'(rf_inData3), 32'd0);
        check("midRstR3", 32'(rf_R3), 32'd0);
        check("midRstCount", 32'(ld_count), 32'd0);
        check("midRstReady", 32'(ld_ready), 32'd1);
        check("midRstStall", 32'(stall_req), 32'd0);
        RST_n = 1'b1;
        tick();
        check("postRstRegWrite", 32'(rf_regWrite), 32'd0);
        check("postRstCount", 32'(ld_count), 32'd0);
        check("postRstReady", 32'(ld_ready), 32'd1);

        // Writeback only
        setWb(1'b1, 2'b00, 3'd5, 16'h1234);
        expQ.push_back({2'b00, 3'd5, 16'h1234});
        tick();
        check("wbRegWrite", 32'(rf_regWrite), 32'd1);
        check("wbR3", 32'(rf_R3), 32'd5);
        check("wbData", 32'(rf_inData3), 32'h1234);
        check("wbSpecGen", 32'(rf_writeSpecReg), 32'd0);
        setWb(1'b1, 2'b01, 3'd5, 16'hBEEF);
        expQ.push_back({2'b01, 3'd5, 16'hBEEF});
        tick();
        check("wbSpecSP", 32'(rf_writeSpecReg), 32'd1);
        setWb(1'b0, 2'b00, 3'd0, 16'h0);
        tick();
        check("idleRegWrite", 32'(rf_regWrite), 32'd0);
        check("idleHoldData", 32'(rf_inData3), 32'hBEEF);
        check("idleHoldSpec", 32'(rf_writeSpecReg), 32'd1);

        // Two loader entries drain in order; full FIFO refuses during a pop cycle
        freeze = 1'b1;
        setLd(1'b1, 2'b10, 3'd3, 16'hAAAA);
        tick();
        setLd(1'b1, 2'b11, 3'd6, 16'h5555);
        tick();
        check("ldFullCount", 32'(ld_count), 32'd2);
        freeze = 1'b0;
        setLd(1'b1, 2'b00, 3'd7, 16'h0F0F);
        expQ.push_back({2'b10, 3'd3, 16'hAAAA});
        expQ.push_back({2'b11, 3'd6, 16'h5555});
        expQ.push_back({2'b00, 3'd7, 16'h0F0F});
        check("ldReadyPopCycle", 32'(ld_ready), 32'd0);
        tick();
        check("ldNoPushWhenFull", 32'(ld_count), 32'd1);
        check("ldFirstSpec", 32'(rf_writeSpecReg), 32'd2);
        tick();
        check("ldPushPopCount", 32'(ld_count), 32'd1);
        check("ldSecondData", 32'(rf_inData3), 32'h5555);
        setLd(1'b0, 2'b00, 3'd0, 16'h0);
        tick();
        check("ldDrainCount", 32'(ld_count), 32'd0);
        check("ldThirdData", 32'(rf_inData3), 32'h0F0F);
        tick();
        check("ldIdleRegWrite", 32'(rf_regWrite), 32'd0);

        // Starvation: continuous writeback with one queued loader entry
        for (int i = 0; i < 7; i++) begin
            setWb(1'b1, 2'b00, 3'(i), 16'h1000 + 16'(i));
            expQ.push_back({2'b00, 3'(i), 16'h1000 + 16'(i)});
            if (i == 0) setLd(1'b1, 2'b01, 3'd2, 16'hCAFE);
            else        setLd(1'b0, 2'b00, 3'd0, 16'h0);
            tick();
            check($sformatf("starveStall%0d", i), 32'(stall_req), (i >= 5) ? 32'd1 : 32'd0);
        end
        setWb(1'b0, 2'b00, 3'd0, 16'h0);
        expQ.push_back({2'b01, 3'd2, 16'hCAFE});
        tick();
        check("starveStallDrop", 32'(stall_req), 32'd0);
        check("starveLdData", 32'(rf_inData3), 32'hCAFE);
        check("starveCount", 32'(ld_count), 32'd0);

        // Freeze for 3 cycles with both requesters active
        setWb(1'b1, 2'b00, 3'd0, 16'h2000);
        expQ.push_back({2'b00, 3'd0, 16'h2000});
        setLd(1'b1, 2'b00, 3'd4, 16'hA0A0);
        tick();
        setWb(1'b1, 2'b00, 3'd1, 16'h2001);
        expQ.push_back({2'b00, 3'd1, 16'h2001});
        setLd(1'b0, 2'b00, 3'd0, 16'h0);
        tick();
        freeze = 1'b1;
        setWb(1'b1, 2'b00, 3'd7, 16'h20FF);
        for (int j = 2; j < 5; j++) begin
            if (j == 2) setLd(1'b1, 2'b10, 3'd1, 16'hB0B0);
            else        setLd(1'b1, 2'b11, 3'd2, 16'hC0C0);
            tick();
            check($sformatf("frzRegWrite%0d", j), 32'(rf_regWrite), 32'd0);
            check($sformatf("frzCount%0d", j), 32'(ld_count), 32'd2);
            check($sformatf("frzStall%0d", j), 32'(stall_req), 32'd0);
        end
        freeze = 1'b0;
        setLd(1'b0, 2'b00, 3'd0, 16'h0);
        for (int j = 5; j < 9; j++) begin
            setWb(1'b1, 2'b00, 3'(j), 16'h2000 + 16'(j));
            expQ.push_back({2'b00, 3'(j), 16'h2000 + 16'(j)});
            tick();
            if (j == 5) check("frzWbFirst", 32'(rf_inData3), 32'h2005);
            check($sformatf("frzHeldCnt%0d", j), 32'(stall_req), (j == 8) ? 32'd1 : 32'd0);
        end
        setWb(1'b0, 2'b00, 3'd0, 16'h0);
        expQ.push_back({2'b00, 3'd4, 16'hA0A0});
        tick();
        check("frzStallDrop", 32'(stall_req), 32'd0);
        check("frzCountAfterA", 32'(ld_count), 32'd1);
        expQ.push_back({2'b10, 3'd1, 16'hB0B0});
        tick();
        check("frzCountAfterB", 32'(ld_count), 32'd0);
        tick();
        check("endRegWrite", 32'(rf_regWrite), 32'd0);
        check("endQueueEmpty", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
